wbu_pipe: RTL and testbench
===========================

Name: wbu_pipe

Overview:
Registered, parametrised writeback stage that replaces the combinational writeback path between LSU and the GPR file. It accepts one instruction per cycle over a valid/ready handshake and holds it in a two-entry skid buffer (main + skid). It selects the writeback data from ALU/MEM/PC/CSR sources, drives the GPR write port with x0 suppression, exposes a forwarding port, and counts retired instructions. It also supports stall and flush.

Parameters:
DATA_WIDTH, 32, GPR write data / source operand width
ADDR_WIDTH, 32, PC width; zero-extended or truncated to DATA_WIDTH when selected
GPRS_WIDTH, 5, GPR index width
SRC_WIDTH, 3, write-source select width
CNT_WIDTH, 64, retire counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept (registered)
i_reg_wr_en  in  1  instruction writes a GPR
i_reg_wr_src  in  SRC_WIDTH  0 NONE, 1 ALU, 2 MEM, 3 PC, 4 CSR, others reserved
i_gpr_wr_id  in  GPRS_WIDTH  destination GPR
i_pc  in  ADDR_WIDTH  instruction PC
i_exu_res  in  DATA_WIDTH  ALU result
i_lsu_res  in  DATA_WIDTH  load data
i_csr_res  in  DATA_WIDTH  CSR read data
i_stall  in  1  hold main entry; no retire this cycle
i_flush  in  1  discard all held entries and any input this cycle
o_gpr_wr_en  out  1  GPR write strobe
o_gpr_wr_id  out  GPRS_WIDTH  GPR write index
o_gpr_wr_data  out  DATA_WIDTH  GPR write data
o_fwd_valid  out  1  main entry holds a pending nonzero-rd write
o_fwd_id  out  GPRS_WIDTH  forwarding index
o_fwd_data  out  DATA_WIDTH  forwarding data
o_retire_valid  out  1  one-cycle pulse per retired instruction
o_retire_pc  out  ADDR_WIDTH  PC of retiring instruction
o_retire_cnt  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, i_rst=1): both entries invalid; o_ready=1; all other outputs 0; o_retire_cnt=0.
- Data select at accept time; result is stored in the entry:
  - ALU→i_exu_res; MEM→i_lsu_res; PC→i_pc resized to DATA_WIDTH; CSR→i_csr_res.
  - NONE or reserved code→0. wr_en is stored as given.
- Events: fire_in = i_valid & o_ready & ~i_flush; fire_out = main_valid & ~i_stall & ~i_flush.
- State machine (EMPTY / ONE / FULL):
  - EMPTY: fire_in→ONE (main←in).
  - ONE: fire_in & fire_out→ONE (main←in); fire_in only→FULL (skid←in); fire_out only→EMPTY.
  - FULL: fire_out→ONE (main←skid). fire_in is impossible because o_ready=0.
  - Any state: i_flush→EMPTY next cycle, overriding every other event. An input presented during flush is dropped.
- o_ready is registered: o_ready = ~skid_valid of the next state (1 in EMPTY/ONE, 0 in FULL). It is never combinationally dependent on i_stall.
- Latency: accept at edge N → write visible on outputs in cycle N+1, provided the stage is not stalled. Throughput is 1/cycle with no stall.
- GPR port, all combinational from main entry:
  - o_gpr_wr_en = fire_out & main.wr_en & (main.id != 0).
  - o_gpr_wr_id and o_gpr_wr_data are 0 when o_gpr_wr_en=0.
- Forwarding:
  - o_fwd_valid = main_valid & main.wr_en & (main.id != 0), independent of i_stall.
  - o_fwd_valid is forced 0 during i_flush.
  - o_fwd_id/o_fwd_data are 0 when o_fwd_valid=0.
- Retire:
  - o_retire_valid = fire_out, including instructions with wr_en=0 or rd=x0.
  - o_retire_pc = main.pc when o_retire_valid=1, else 0.
  - o_retire_cnt increments by 1 at every edge with fire_out and wraps modulo 2^CNT_WIDTH. Flushed entries are not counted.
- Ordering: instructions retire strictly in accept order; skid never overtakes main.
- Reset mid-operation: immediate clear regardless of state; no retire pulse.

Test Plan:
- Back-to-back: 3 instrs ALU res 0x11/0x22/0x33 to x1/x2/x3, no stall → writes x1=0x11, x2=0x22, x3=0x33 on 3 consecutive cycles starting 1 cycle after first accept; o_ready stays 1; o_retire_cnt=3.
- Stall fill: hold i_stall=1 and send 2 instrs → state FULL, o_ready=0; release stall → retire in order over 2 cycles; o_ready returns 1 one cycle after the first retire.
- Source mux: MEM (lsu=0xDEAD_BEEF), PC (pc=0x8000_0004), CSR (0x1234), reserved 7 → write data 0xDEADBEEF, 0x80000004, 0x1234, 0x0.
- x0 / no-write: wr_id=0 with wr_en=1, and wr_en=0 to x5 → o_gpr_wr_en=0 for both, o_fwd_valid=0, o_retire_valid pulses twice, count +2.
- Flush: state FULL, assert i_flush together with i_valid → next cycle EMPTY, o_ready=1, no writes, no retire, count unchanged; the input presented during flush never appears.
- Async reset + wrap: CNT_WIDTH=4, retire 17 instrs → cnt=1; assert i_rst between edges → outputs 0 and o_ready=1 immediately.

Source files
------------

// File: rtl/wbu_pipe_if.sv
// Writeback stage bus: upstream handshake, operand sources, GPR write port,
// forwarding port and retire port bundled into one interface.
interface wbu_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int GPRS_WIDTH = 5,
    parameter int SRC_WIDTH  = 3,
    parameter int CNT_WIDTH  = 64
);
    logic                  i_valid;
    logic                  o_ready;
    logic                  i_reg_wr_en;
    logic [SRC_WIDTH-1:0]  i_reg_wr_src;
    logic [GPRS_WIDTH-1:0] i_gpr_wr_id;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic [DATA_WIDTH-1:0] i_exu_res;
    logic [DATA_WIDTH-1:0] i_lsu_res;
    logic [DATA_WIDTH-1:0] i_csr_res;
    logic                  i_stall;
    logic                  i_flush;
    logic                  o_gpr_wr_en;
    logic [GPRS_WIDTH-1:0] o_gpr_wr_id;
    logic [DATA_WIDTH-1:0] o_gpr_wr_data;
    logic                  o_fwd_valid;
    logic [GPRS_WIDTH-1:0] o_fwd_id;
    logic [DATA_WIDTH-1:0] o_fwd_data;
    logic                  o_retire_valid;
    logic [ADDR_WIDTH-1:0] o_retire_pc;
    logic [CNT_WIDTH-1:0]  o_retire_cnt;

    // The writeback stage itself
    modport slave (
        input  i_valid, i_reg_wr_en, i_reg_wr_src, i_gpr_wr_id, i_pc,
               i_exu_res, i_lsu_res, i_csr_res, i_stall, i_flush,
        output o_ready, o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data,
               o_fwd_valid, o_fwd_id, o_fwd_data,
               o_retire_valid, o_retire_pc, o_retire_cnt
    );

    // The upstream pipeline / GPR file side
    modport master (
        output i_valid, i_reg_wr_en, i_reg_wr_src, i_gpr_wr_id, i_pc,
               i_exu_res, i_lsu_res, i_csr_res, i_stall, i_flush,
        input  o_ready, o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data,
               o_fwd_valid, o_fwd_id, o_fwd_data,
               o_retire_valid, o_retire_pc, o_retire_cnt
    );
endinterface

// File: rtl/wbu_pipe.sv
// Registered writeback stage with a two-entry (main + skid) buffer.
// Selects writeback data at accept time, drives the GPR write port with x0
// suppression, exposes a forwarding port and counts retired instructions.
module wbu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int GPRS_WIDTH = 5,
    parameter int SRC_WIDTH  = 3,
    parameter int CNT_WIDTH  = 64
) (
    input logic       i_clk,
    input logic       i_rst,
    wbu_pipe_if.slave bus
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [SRC_WIDTH-1:0] SRC_ALU = SRC_WIDTH'(1);
    localparam logic [SRC_WIDTH-1:0] SRC_MEM = SRC_WIDTH'(2);
    localparam logic [SRC_WIDTH-1:0] SRC_PC  = SRC_WIDTH'(3);
    localparam logic [SRC_WIDTH-1:0] SRC_CSR = SRC_WIDTH'(4);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic                  ready_q;
    logic [CNT_WIDTH-1:0]  retire_cnt;

    logic                  main_wr_en;
    logic [GPRS_WIDTH-1:0] main_id;
    logic [DATA_WIDTH-1:0] main_data;
    logic [ADDR_WIDTH-1:0] main_pc;
    logic                  skid_wr_en;
    logic [GPRS_WIDTH-1:0] skid_id;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [ADDR_WIDTH-1:0] skid_pc;

    logic                  main_valid;
    logic                  fire_in;
    logic                  fire_out;
    logic                  main_writes;
    logic                  gpr_wr_en;
    logic                  fwd_valid;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;
    logic [DATA_WIDTH-1:0] pc_ext;
    logic [DATA_WIDTH-1:0] in_data;

    // PC is zero-extended or truncated so it can be written into a GPR
    generate
        if (ADDR_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
            assign pc_ext = bus.i_pc[DATA_WIDTH-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, bus.i_pc};
        end
    endgenerate

    assign main_valid  = (state != ST_EMPTY);
    assign fire_in     = bus.i_valid & ready_q & ~bus.i_flush;
    assign fire_out    = main_valid & ~bus.i_stall & ~bus.i_flush;
    assign main_writes = main_wr_en & (main_id != '0);
    assign gpr_wr_en   = fire_out & main_writes;
    assign fwd_valid   = main_valid & main_writes & ~bus.i_flush;

    // Writeback source select; reserved codes and NONE write zero
    always_comb begin
        in_data = '0;
        case (bus.i_reg_wr_src)
            SRC_ALU: in_data = bus.i_exu_res;
            SRC_MEM: in_data = bus.i_lsu_res;
            SRC_PC:  in_data = pc_ext;
            SRC_CSR: in_data = bus.i_csr_res;
            default: in_data = '0;
        endcase
    end

    // Occupancy transitions and which entry gets loaded from where
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (fire_in) begin
                    next_state   = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (fire_in && fire_out) begin
                    next_state   = ST_ONE;
                    load_main_in = 1'b1;
                end else if (fire_in) begin
                    next_state = ST_FULL;
                    load_skid  = 1'b1;
                end else if (fire_out) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fire_out) begin
                    next_state     = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
        if (bus.i_flush) begin
            next_state = ST_EMPTY;
        end
    end

    // State register; ready is registered from the next occupancy so it never depends on stall combinationally
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != ST_FULL);
        end
    end

    // Entry payloads; main refills from skid so skid never overtakes main
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_wr_en <= 1'b0;
            main_id    <= '0;
            main_data  <= '0;
            main_pc    <= '0;
            skid_wr_en <= 1'b0;
            skid_id    <= '0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else begin
            if (load_main_in) begin
                main_wr_en <= bus.i_reg_wr_en;
                main_id    <= bus.i_gpr_wr_id;
                main_data  <= in_data;
                main_pc    <= bus.i_pc;
            end else if (load_main_skid) begin
                main_wr_en <= skid_wr_en;
                main_id    <= skid_id;
                main_data  <= skid_data;
                main_pc    <= skid_pc;
            end
            if (load_skid) begin
                skid_wr_en <= bus.i_reg_wr_en;
                skid_id    <= bus.i_gpr_wr_id;
                skid_data  <= in_data;
                skid_pc    <= bus.i_pc;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retire_cnt <= '0;
        end else if (fire_out) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign bus.o_ready        = ready_q;
    assign bus.o_gpr_wr_en    = gpr_wr_en;
    assign bus.o_gpr_wr_id    = gpr_wr_en ? main_id : '0;
    assign bus.o_gpr_wr_data  = gpr_wr_en ? main_data : '0;
    assign bus.o_fwd_valid    = fwd_valid;
    assign bus.o_fwd_id       = fwd_valid ? main_id : '0;
    assign bus.o_fwd_data     = fwd_valid ? main_data : '0;
    assign bus.o_retire_valid = fire_out;
    assign bus.o_retire_pc    = fire_out ? main_pc : '0;
    assign bus.o_retire_cnt   = retire_cnt;

endmodule

// File: tb/tb_wbu_pipe.sv
// Scoreboard bench for wbu_pipe: directed stimulus pushes expected retires,
// a negedge monitor pops and compares them against the GPR/retire ports.
module tb_wbu_pipe;
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_ALU  = 3'd1;
    localparam logic [2:0] SRC_MEM  = 3'd2;
    localparam logic [2:0] SRC_PC   = 3'd3;
    localparam logic [2:0] SRC_CSR  = 3'd4;

    typedef struct {
        logic        en;
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic       clk;
    logic       rst;
    int         checks;
    int         failures;
    logic [3:0] exp_cnt;
    exp_t       sb[$];

    wbu_pipe_if #(.CNT_WIDTH(4)) bus ();

    wbu_pipe #(.CNT_WIDTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Presents one instruction for one edge; push=1 records it as an expected retire
    task automatic applyStimulus(input logic push, input logic wr_en, input logic [2:0] src,
                                 input logic [4:0] id, input logic [31:0] pc,
                                 input logic [31:0] exu, input logic [31:0] lsu,
                                 input logic [31:0] csr, input logic [31:0] expd);
        exp_t e;
        bus.i_valid      = 1'b1;
        bus.i_reg_wr_en  = wr_en;
        bus.i_reg_wr_src = src;
        bus.i_gpr_wr_id  = id;
        bus.i_pc         = pc;
        bus.i_exu_res    = exu;
        bus.i_lsu_res    = lsu;
        bus.i_csr_res    = csr;
        if (push) begin
            e.en   = wr_en && (id != 5'd0);
            e.id   = e.en ? id : 5'd0;
            e.data = e.en ? expd : 32'd0;
            e.pc   = pc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mid-cycle asynchronous reset with immediate output checks
    task automatic midReset();
        #2;
        rst = 1'b1;
        sb.delete();
        exp_cnt = 4'd0;
        #1;
        checkOutput("rst_ready", {63'd0, bus.o_ready}, 64'd1);
        checkOutput("rst_gpr_wr_en", {63'd0, bus.o_gpr_wr_en}, 64'd0);
        checkOutput("rst_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd0);
        checkOutput("rst_retire_valid", {63'd0, bus.o_retire_valid}, 64'd0);
        checkOutput("rst_retire_cnt", {60'd0, bus.o_retire_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every retire against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_retire_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_retire actual pc=%0h required=no retire", bus.o_retire_pc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("gpr_wr_en", {63'd0, bus.o_gpr_wr_en}, {63'd0, e.en});
                        checkOutput("gpr_wr_id", {59'd0, bus.o_gpr_wr_id}, {59'd0, e.id});
                        checkOutput("gpr_wr_data", {32'd0, bus.o_gpr_wr_data}, {32'd0, e.data});
                        checkOutput("retire_pc", {32'd0, bus.o_retire_pc}, {32'd0, e.pc});
                        checkOutput("retire_cnt", {60'd0, bus.o_retire_cnt}, {60'd0, exp_cnt});
                        exp_cnt = exp_cnt + 4'd1;
                    end
                end else begin
                    checkOutput("idle_gpr_wr_en", {63'd0, bus.o_gpr_wr_en}, 64'd0);
                    checkOutput("idle_retire_pc", {32'd0, bus.o_retire_pc}, 64'd0);
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 4'd0;
        rst      = 1'b1;
        bus.i_valid      = 1'b0;
        bus.i_reg_wr_en  = 1'b0;
        bus.i_reg_wr_src = SRC_NONE;
        bus.i_gpr_wr_id  = 5'd0;
        bus.i_pc         = 32'd0;
        bus.i_exu_res    = 32'd0;
        bus.i_lsu_res    = 32'd0;
        bus.i_csr_res    = 32'd0;
        bus.i_stall      = 1'b0;
        bus.i_flush      = 1'b0;
        #3;
        checkOutput("reset_ready", {63'd0, bus.o_ready}, 64'd1);
        checkOutput("reset_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd0);
        checkOutput("reset_retire_valid", {63'd0, bus.o_retire_valid}, 64'd0);
        checkOutput("reset_retire_cnt", {60'd0, bus.o_retire_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Back-to-back ALU writes
        applyStimulus(1, 1, SRC_ALU, 5'd1, 32'h0000_0100, 32'h11, 32'hF0, 32'hF1, 32'h11);
        checkOutput("b2b_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd1);
        checkOutput("b2b_fwd_id", {59'd0, bus.o_fwd_id}, 64'd1);
        checkOutput("b2b_fwd_data", {32'd0, bus.o_fwd_data}, 64'h11);
        checkOutput("b2b_ready1", {63'd0, bus.o_ready}, 64'd1);
        applyStimulus(1, 1, SRC_ALU, 5'd2, 32'h0000_0104, 32'h22, 32'hF0, 32'hF1, 32'h22);
        checkOutput("b2b_ready2", {63'd0, bus.o_ready}, 64'd1);
        applyStimulus(1, 1, SRC_ALU, 5'd3, 32'h0000_0108, 32'h33, 32'hF0, 32'hF1, 32'h33);
        checkOutput("b2b_ready3", {63'd0, bus.o_ready}, 64'd1);
        idle(1);
        checkOutput("b2b_cnt", {60'd0, bus.o_retire_cnt}, 64'd3);

        // Stall fill to FULL, then drain in order
        bus.i_stall = 1'b1;
        applyStimulus(1, 1, SRC_ALU, 5'd4, 32'h0000_0200, 32'h44, 32'd0, 32'd0, 32'h44);
        checkOutput("stall_ready_one", {63'd0, bus.o_ready}, 64'd1);
        applyStimulus(1, 1, SRC_ALU, 5'd5, 32'h0000_0204, 32'h55, 32'd0, 32'd0, 32'h55);
        checkOutput("stall_ready_full", {63'd0, bus.o_ready}, 64'd0);
        checkOutput("stall_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd1);
        checkOutput("stall_fwd_id", {59'd0, bus.o_fwd_id}, 64'd4);
        checkOutput("stall_retire_valid", {63'd0, bus.o_retire_valid}, 64'd0);
        idle(1);
        checkOutput("stall_hold_ready", {63'd0, bus.o_ready}, 64'd0);
        bus.i_stall = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stall_ready_back", {63'd0, bus.o_ready}, 64'd1);
        checkOutput("stall_fwd_id_skid", {59'd0, bus.o_fwd_id}, 64'd5);
        idle(2);
        checkOutput("stall_cnt", {60'd0, bus.o_retire_cnt}, {60'd0, exp_cnt});

        // Source mux: MEM, PC, CSR, reserved
        applyStimulus(1, 1, SRC_MEM, 5'd6, 32'h0000_0300, 32'hAAAA, 32'hDEAD_BEEF, 32'hBBBB, 32'hDEAD_BEEF);
        applyStimulus(1, 1, SRC_PC,  5'd7, 32'h8000_0004, 32'hAAAA, 32'hCCCC, 32'hBBBB, 32'h8000_0004);
        applyStimulus(1, 1, SRC_CSR, 5'd8, 32'h0000_0308, 32'hAAAA, 32'hCCCC, 32'h1234, 32'h0000_1234);
        applyStimulus(1, 1, 3'd7,    5'd9, 32'h0000_030C, 32'hAAAA, 32'hCCCC, 32'hBBBB, 32'h0000_0000);
        idle(2);

        // x0 destination and wr_en=0: retire without writing
        applyStimulus(1, 1, SRC_ALU, 5'd0, 32'h0000_0400, 32'h99, 32'd0, 32'd0, 32'h99);
        checkOutput("x0_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd0);
        applyStimulus(1, 0, SRC_ALU, 5'd5, 32'h0000_0404, 32'h77, 32'd0, 32'd0, 32'h77);
        checkOutput("nowr_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd0);
        idle(2);
        checkOutput("nowr_cnt", {60'd0, bus.o_retire_cnt}, {60'd0, exp_cnt});

        // Flush from FULL with a simultaneous input that must be dropped
        bus.i_stall = 1'b1;
        applyStimulus(0, 1, SRC_ALU, 5'd10, 32'h0000_0500, 32'hAA, 32'd0, 32'd0, 32'hAA);
        applyStimulus(0, 1, SRC_ALU, 5'd11, 32'h0000_0504, 32'hBB, 32'd0, 32'd0, 32'hBB);
        checkOutput("flush_pre_ready", {63'd0, bus.o_ready}, 64'd0);
        bus.i_flush      = 1'b1;
        bus.i_valid      = 1'b1;
        bus.i_reg_wr_en  = 1'b1;
        bus.i_reg_wr_src = SRC_ALU;
        bus.i_gpr_wr_id  = 5'd12;
        bus.i_pc         = 32'h0000_0508;
        bus.i_exu_res    = 32'hCC;
        #1;
        checkOutput("flush_fwd_valid", {63'd0, bus.o_fwd_valid}, 64'd0);
        checkOutput("flush_retire_valid", {63'd0, bus.o_retire_valid}, 64'd0);
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_stall = 1'b0;
        checkOutput("flush_ready", {63'd0, bus.o_ready}, 64'd1);
        checkOutput("flush_fwd_after", {63'd0, bus.o_fwd_valid}, 64'd0);
        idle(3);
        checkOutput("flush_cnt", {60'd0, bus.o_retire_cnt}, {60'd0, exp_cnt});

        // Counter wrap at 4 bits: 17 retires from zero leave 1
        midReset();
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1, 1, SRC_ALU, 5'd13, 32'h0000_1000 + 32'(k * 4), 32'h1000 + 32'(k),
                          32'd0, 32'd0, 32'h1000 + 32'(k));
        end
        idle(2);
        checkOutput("wrap_cnt", {60'd0, bus.o_retire_cnt}, 64'd1);

        // Async reset while an instruction is retiring
        applyStimulus(1, 1, SRC_ALU, 5'd14, 32'h0000_2000, 32'hEE, 32'd0, 32'd0, 32'hEE);
        checkOutput("pre_rst_retire_valid", {63'd0, bus.o_retire_valid}, 64'd1);
        midReset();
        idle(2);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        checkOutput("post_rst_cnt", {60'd0, bus.o_retire_cnt}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
